// File: rtl/jtdd2_dwnld_pkg.sv
// Shared constants and types for the DD2 download translator.
// Optional build macro: JTDD2_DWNLD_CHECKSUM_EN (see jtdd2_dwnld.sv).
package jtdd2_dwnld_pkg;

    // Byte addresses of the ioctl ROM regions
    localparam logic [21:0] CHAR_ADDR  = 22'h080000;
    localparam logic [21:0] SCRZW_ADDR = 22'h090000;
    localparam logic [21:0] SCRXY_ADDR = 22'h0B0000;
    localparam logic [21:0] OBJWZ_ADDR = 22'h0D0000;
    localparam logic [21:0] OBJXY_ADDR = 22'h130000;
    localparam logic [21:0] PROM_ADDR  = 22'h190000;
    localparam logic [21:0] PROM_END   = 22'h190200;

    // SDRAM word bases of the interleaved planes
    localparam logic [21:0] SCR_SDRAM  = 22'h060000;
    localparam logic [21:0] OBJ_SDRAM  = 22'h080000;

    // Active-low byte enables
    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_HI   = 2'b01;
    localparam logic [1:0] MASK_NONE = 2'b11;

    typedef struct packed {
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
        logic        is_prom;
    } entry_t;

    localparam int ENTRY_W = 22 + 8 + 2 + 1;

    typedef enum logic [2:0] {
        REG_MAIN, REG_CHAR, REG_SCRZW, REG_SCRXY,
        REG_OBJWZ, REG_OBJXY, REG_PROM, REG_DROP
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // Classify a byte address into its ROM region
    function automatic region_e region_of(input logic [21:0] a);
        if      (a < CHAR_ADDR)  return REG_MAIN;
        else if (a < SCRZW_ADDR) return REG_CHAR;
        else if (a < SCRXY_ADDR) return REG_SCRZW;
        else if (a < OBJWZ_ADDR) return REG_SCRXY;
        else if (a < OBJXY_ADDR) return REG_OBJWZ;
        else if (a < PROM_ADDR)  return REG_OBJXY;
        else if (a < PROM_END)   return REG_PROM;
        else                     return REG_DROP;
    endfunction

endpackage

// File: rtl/jtdd2_dwnld_if.sv
// Download-side bus: ioctl byte stream in, SDRAM/PROM programming out.
interface jtdd2_dwnld_if;
    logic        downloading;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        sdram_ack;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        prom_we;
    logic        dwnld_busy;
    logic        overflow;
    logic [15:0] checksum;

    // The translator: consumes the ioctl stream, issues programming writes
    modport master (
        input  downloading, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
        output prog_addr, prog_data, prog_mask, prog_we, prom_we,
        dwnld_busy, overflow, checksum
    );

    // The environment: ioctl source and SDRAM slot controller
    modport slave (
        output downloading, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
        input  prog_addr, prog_data, prog_mask, prog_we, prom_we,
        dwnld_busy, overflow, checksum
    );
endinterface

// File: rtl/jtdd2_dwnld_fifo.sv
// Two-entry queue with same-cycle push/pop and synchronous flush.
module jtdd2_dwnld_fifo
    import jtdd2_dwnld_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   push,
    input  entry_t wr_entry,
    input  logic   pop,
    output entry_t rd_entry,
    output logic   push_ok,
    output logic   empty,
    output logic   full
);

    logic [ENTRY_W-1:0] mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;
    logic               pop_ok;

    assign empty    = (count == 2'd0);
    assign full     = (count == 2'd2);
    // A full queue still accepts a byte when the head leaves in the same cycle
    assign push_ok  = push && !flush && (!full || pop);
    assign pop_ok   = pop && !empty && !flush;
    assign rd_entry = entry_t'(mem[rd_ptr]);

    // Storage write
    // NOTE: payload storage carries no reset; occupancy is tracked by count, so stale data is never read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= ENTRY_W'(wr_entry);
    end

    // Pointer and occupancy tracking
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            wr_ptr <= wr_ptr ^ push_ok;
            rd_ptr <= rd_ptr ^ pop_ok;
            count  <= count + 2'(push_ok) - 2'(pop_ok);
        end
    end

endmodule

// File: rtl/jtdd2_dwnld.sv
// DD2 download translator: ioctl bytes -> interleaved SDRAM writes / PROM strobes.
// Optional macro JTDD2_DWNLD_CHECKSUM_EN builds a 16-bit sum of queued bytes.
module jtdd2_dwnld
    import jtdd2_dwnld_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    jtdd2_dwnld_if.master bus
);

    entry_t  in_entry, head;
    logic    in_keep, push_req, push_ok, empty, full;
    logic    dl_d, dl_rise;
    logic    pop, load_sdram, load_prom;
    state_e  state, state_nxt;

    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we, prom_we, overflow;

    assign dl_rise  = bus.downloading && !dl_d;
    assign push_req = bus.ioctl_wr && bus.downloading && in_keep;

    // Translate the current ioctl byte into a queue entry
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        logic [21:0] a;
        a        = bus.ioctl_addr;
        in_keep  = 1'b1;
        in_entry = '{addr: {1'b0, a[21:1]}, data: bus.ioctl_data,
                     mask: a[0] ? MASK_HI : MASK_LO, is_prom: 1'b0};
        unique case (region_of(a))
            REG_SCRZW: begin in_entry.addr = SCR_SDRAM + (a - SCRZW_ADDR); in_entry.mask = MASK_LO; end
            REG_SCRXY: begin in_entry.addr = SCR_SDRAM + (a - SCRXY_ADDR); in_entry.mask = MASK_HI; end
            REG_OBJWZ: begin in_entry.addr = OBJ_SDRAM + (a - OBJWZ_ADDR); in_entry.mask = MASK_LO; end
            REG_OBJXY: begin in_entry.addr = OBJ_SDRAM + (a - OBJXY_ADDR); in_entry.mask = MASK_HI; end
            REG_PROM: begin
                in_entry.addr    = a - PROM_ADDR;
                in_entry.mask    = MASK_NONE;
                in_entry.is_prom = 1'b1;
            end
            REG_DROP: in_keep = 1'b0;
            default: ;
        endcase
    end

    jtdd2_dwnld_fifo u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (dl_rise),
        .push     (push_req),
        .wr_entry (in_entry),
        .pop      (pop),
        .rd_entry (head),
        .push_ok  (push_ok),
        .empty    (empty),
        .full     (full)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // FSM next state; a new download always restarts from idle
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (!empty) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = head.is_prom ? ST_IDLE : ST_WAIT;
            ST_WAIT:  if (bus.sdram_ack) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (dl_rise) state_nxt = ST_IDLE;
    end

    // FSM outputs: load the head into the prog registers and pop when done
    always_comb begin
        load_prom  = (state == ST_ISSUE) &&  head.is_prom && !dl_rise;
        load_sdram = (state == ST_ISSUE) && !head.is_prom && !dl_rise;
        pop        = load_prom || ((state == ST_WAIT) && bus.sdram_ack);
    end

    // Programming outputs, download-edge detector and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_d      <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= '0;
            prog_we   <= 1'b0;
            prom_we   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            dl_d    <= bus.downloading;
            prom_we <= load_prom;
            if (load_prom || load_sdram) begin
                prog_addr <= head.addr;
                prog_data <= head.data;
                prog_mask <= head.mask;
            end
            if (dl_rise) begin
                prog_we  <= 1'b0;
                overflow <= 1'b0;
            end else begin
                if (load_sdram)                                   prog_we <= 1'b1;
                else if ((state == ST_WAIT) && bus.sdram_ack)     prog_we <= 1'b0;
                if (push_req && !push_ok)                         overflow <= 1'b1;
            end
        end
    end

`ifdef JTDD2_DWNLD_CHECKSUM_EN
    logic [15:0] sum;

    // Wrapping sum of every byte accepted into the queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       sum <= 16'd0;
        else if (dl_rise) sum <= 16'd0;
        else if (push_ok) sum <= sum + {8'd0, bus.ioctl_data};
    end
    assign bus.checksum = sum;
`else
    assign bus.checksum = 16'd0;
`endif

    assign bus.prog_addr  = prog_addr;
    assign bus.prog_data  = prog_data;
    assign bus.prog_mask  = prog_mask;
    assign bus.prog_we    = prog_we;
    assign bus.prom_we    = prom_we;
    assign bus.overflow   = overflow;
    assign bus.dwnld_busy = bus.downloading || !empty || prog_we;

endmodule

// File: tb/tb_jtdd2_dwnld.sv
// Directed bench for jtdd2_dwnld: region table plus multi-cycle corner sequences.
module tb_jtdd2_dwnld;

    logic clk = 1'b0;
    logic rst_n;

    jtdd2_dwnld_if bus ();

    jtdd2_dwnld dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [21:0] addr;
        logic [7:0]  data;
        int          kind;      // 0 = SDRAM write, 1 = PROM strobe, 2 = nothing
        logic [21:0] exp_addr;
        logic [1:0]  exp_mask;
    } vec_t;

    vec_t vecs [14];

`ifdef JTDD2_DWNLD_CHECKSUM_EN
    localparam logic [15:0] EXP_SUM = 16'h0201;
`else
    localparam logic [15:0] EXP_SUM = 16'h0000;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one byte for exactly one clock edge
    task automatic send_byte(input logic [21:0] a, input logic [7:0] d);
        bus.ioctl_addr = a;
        bus.ioctl_data = d;
        bus.ioctl_wr   = 1'b1;
        step();
        bus.ioctl_wr   = 1'b0;
    endtask

    // Wait (bounded) for prog_we or prom_we; lat counts edges waited
    task automatic wait_issue(output bit found, output int lat);
        found = 1'b0;
        lat   = 0;
        for (int i = 0; i <= 12; i++) begin
            if (bus.prog_we || bus.prom_we) begin
                found = 1'b1;
                lat   = i;
                break;
            end
            step();
        end
    endtask

    task automatic ack_we(input string name);
        bus.sdram_ack = 1'b1;
        step();
        bus.sdram_ack = 1'b0;
        check(name, bus.prog_we, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit found;
        int lat;

        vecs[0]  = '{22'h000000, 8'h12, 0, 22'h000000, 2'b10};
        vecs[1]  = '{22'h080003, 8'h34, 0, 22'h040001, 2'b01};
        vecs[2]  = '{22'h08FFFF, 8'hAA, 0, 22'h047FFF, 2'b01};
        vecs[3]  = '{22'h090010, 8'h11, 0, 22'h060010, 2'b10};
        vecs[4]  = '{22'h0B0010, 8'h22, 0, 22'h060010, 2'b01};
        vecs[5]  = '{22'h0AFFFF, 8'hAB, 0, 22'h07FFFF, 2'b10};
        vecs[6]  = '{22'h0D0000, 8'h33, 0, 22'h080000, 2'b10};
        vecs[7]  = '{22'h12FFFF, 8'h44, 0, 22'h0DFFFF, 2'b10};
        vecs[8]  = '{22'h130005, 8'h55, 0, 22'h080005, 2'b01};
        vecs[9]  = '{22'h18FFFF, 8'h66, 0, 22'h0DFFFF, 2'b01};
        vecs[10] = '{22'h190003, 8'h77, 1, 22'h000003, 2'b11};
        vecs[11] = '{22'h1901FF, 8'h88, 1, 22'h0001FF, 2'b11};
        vecs[12] = '{22'h190200, 8'h99, 2, 22'h000000, 2'b00};
        vecs[13] = '{22'h3FFFFF, 8'h9A, 2, 22'h000000, 2'b00};

        rst_n           = 1'b0;
        bus.downloading = 1'b0;
        bus.ioctl_addr  = '0;
        bus.ioctl_data  = '0;
        bus.ioctl_wr    = 1'b0;
        bus.sdram_ack   = 1'b0;
        #12;
        check("rst_prog_addr", bus.prog_addr, 0);
        check("rst_prog_we", bus.prog_we, 0);
        check("rst_prom_we", bus.prom_we, 0);
        check("rst_busy", bus.dwnld_busy, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_checksum", bus.checksum, 0);
        step();
        rst_n = 1'b1;
        step();

        // ioctl_wr without downloading is ignored
        send_byte(22'h000002, 8'hEE);
        wait_issue(found, lat);
        check("ignored_no_dl", found, 0);

        bus.downloading = 1'b1;
        step();
        step();

        // First byte: write held three cycles, drops after ack
        send_byte(22'h000001, 8'h5A);
        wait_issue(found, lat);
        check("t1_found", found, 1);
        check("t1_lat", lat, 2);
        check("t1_addr", bus.prog_addr, 22'h000000);
        check("t1_mask", bus.prog_mask, 2'b01);
        check("t1_data", bus.prog_data, 8'h5A);
        step();
        check("t1_hold1", bus.prog_we, 1);
        check("t1_hold_addr", bus.prog_addr, 22'h000000);
        step();
        check("t1_hold2", bus.prog_we, 1);
        ack_we("t1_drop");

        // Region table
        for (int i = 0; i < 14; i++) begin
            send_byte(vecs[i].addr, vecs[i].data);
            wait_issue(found, lat);
            if (vecs[i].kind == 2) begin
                check($sformatf("v%0d_none", i), found, 0);
            end else begin
                check($sformatf("v%0d_found", i), found, 1);
                check($sformatf("v%0d_lat", i), lat, 2);
                check($sformatf("v%0d_addr", i), bus.prog_addr, vecs[i].exp_addr);
                check($sformatf("v%0d_data", i), bus.prog_data, vecs[i].data);
                if (vecs[i].kind == 1) begin
                    check($sformatf("v%0d_prom", i), bus.prom_we, 1);
                    check($sformatf("v%0d_no_we", i), bus.prog_we, 0);
                    step();
                    check($sformatf("v%0d_prom_1cyc", i), bus.prom_we, 0);
                    check($sformatf("v%0d_no_we2", i), bus.prog_we, 0);
                end else begin
                    check($sformatf("v%0d_mask", i), bus.prog_mask, vecs[i].exp_mask);
                    check($sformatf("v%0d_not_prom", i), bus.prom_we, 0);
                    ack_we($sformatf("v%0d_drop", i));
                end
            end
        end

        // Three back-to-back bytes with ack withheld: the third is lost
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 22'h090000; bus.ioctl_data = 8'hA1; step();
        bus.ioctl_addr = 22'h090001; bus.ioctl_data = 8'hA2; step();
        bus.ioctl_addr = 22'h090002; bus.ioctl_data = 8'hA3; step();
        bus.ioctl_wr   = 1'b0;
        check("ovf_set", bus.overflow, 1);
        wait_issue(found, lat);
        check("ovf_first_found", found, 1);
        check("ovf_first_addr", bus.prog_addr, 22'h060000);
        check("ovf_first_data", bus.prog_data, 8'hA1);
        ack_we("ovf_first_drop");
        wait_issue(found, lat);
        check("ovf_second_found", found, 1);
        check("ovf_second_addr", bus.prog_addr, 22'h060001);
        check("ovf_second_data", bus.prog_data, 8'hA2);
        ack_we("ovf_second_drop");
        wait_issue(found, lat);
        check("ovf_third_lost", found, 0);
        check("ovf_sticky", bus.overflow, 1);

        // Falling edge with two bytes queued: queue drains, then idle
        send_byte(22'h000010, 8'hC1);
        send_byte(22'h000011, 8'hC2);
        bus.downloading = 1'b0;
        wait_issue(found, lat);
        check("fall_first_found", found, 1);
        check("fall_first_addr", bus.prog_addr, 22'h000008);
        check("fall_first_mask", bus.prog_mask, 2'b10);
        check("fall_busy1", bus.dwnld_busy, 1);
        ack_we("fall_first_drop");
        check("fall_busy2", bus.dwnld_busy, 1);
        wait_issue(found, lat);
        check("fall_second_found", found, 1);
        check("fall_second_data", bus.prog_data, 8'hC2);
        check("fall_second_mask", bus.prog_mask, 2'b01);
        check("fall_busy3", bus.dwnld_busy, 1);
        ack_we("fall_second_drop");
        check("fall_idle", bus.dwnld_busy, 0);
        check("fall_ovf_kept", bus.overflow, 1);

        // Rising edge clears overflow and checksum
        bus.downloading = 1'b1;
        step();
        check("rise_ovf_clr", bus.overflow, 0);
        check("rise_sum_clr", bus.checksum, 0);

        // Checksum over 0xFF, 0xFF, 0x03
        send_byte(22'h000100, 8'hFF);
        wait_issue(found, lat);
        ack_we("sum_b0_drop");
        send_byte(22'h000101, 8'hFF);
        wait_issue(found, lat);
        ack_we("sum_b1_drop");
        send_byte(22'h000102, 8'h03);
        wait_issue(found, lat);
        ack_we("sum_b2_drop");
        check("checksum", bus.checksum, EXP_SUM);

        // Asynchronous reset in the middle of a pending write
        send_byte(22'h000200, 8'h7E);
        wait_issue(found, lat);
        check("arst_pending", bus.prog_we, 1);
        bus.downloading = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_we", bus.prog_we, 0);
        check("arst_addr", bus.prog_addr, 0);
        check("arst_data", bus.prog_data, 0);
        check("arst_busy", bus.dwnld_busy, 0);
        check("arst_sum", bus.checksum, 0);
        step();
        rst_n = 1'b1;
        step();
        wait_issue(found, lat);
        check("arst_queue_empty", found, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
